spi_reg_master: RTL and testbench

SPI initiator that issues single register read/write transactions to a remote SPI register slave. It serialises a 16-bit command word and a 16-bit data word, and returns read data to a local requester. It is used as the on-chip bus-functional master for self-test and loopback of the register interface, and for driving external SPI-register peripherals. The mode is fixed at CPOL=0, CPHA=0, MSB first.

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_half_tick.sv | 28 ++
 rtl/spi_reg_master.sv | 133 +++++++++++++
 tb/tb_spi_reg_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared frame layout, FSM states and remote register map for the SPI register link.
package spi_pkg;

    localparam int FRAME_BITS = 32;
    localparam int RW_BIT     = 31;
    localparam int ADDR_MSB   = 30;
    localparam int ADDR_LSB   = 16;
    localparam int DATA_BITS  = 16;
    localparam int ADDR_BITS  = ADDR_MSB - ADDR_LSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    localparam logic [ADDR_BITS-1:0] CONTROL    = 15'd0;
    localparam logic [ADDR_BITS-1:0] EQ_TAP_SEL = 15'd1;
    localparam logic [ADDR_BITS-1:0] MPIO_SEL   = 15'd2;
    localparam logic [ADDR_BITS-1:0] SRAM_SEL   = 15'd3;
    localparam logic [ADDR_BITS-1:0] STATUS     = 15'd4;
    localparam logic [ADDR_BITS-1:0] MOTOR      = 15'd5;
    localparam logic [ADDR_BITS-1:0] AUX        = 15'd6;
    localparam logic [ADDR_BITS-1:0] TEST       = 15'd7;

    // Reads put zeros in the data field; the slave drives its answer on miso instead.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data
    );
        return {rw, addr, rw ? {DATA_BITS{1'b0}} : data};
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Prescaler: one-cycle tick every CLK_DIV clocks while enabled, restarting on each enable.
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Held at zero while disabled, so the first tick lands CLK_DIV cycles after enable rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (!i_en || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator: one 32-bit command+data frame per request, read data returned locally.
module spi_reg_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rw,
    input  logic [14:0] addr,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        spi_cs0,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    import spi_pkg::*;

    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                                                  : ((CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP - 1);

    spi_state_e             r_state;
    logic [CW-1:0]          r_cnt;
    logic [4:0]             r_bit;
    logic [FRAME_BITS-1:0]  r_tx;
    logic [DATA_BITS-1:0]   r_rx;
    logic                   r_rw;
    logic                   r_busy;
    logic                   r_done;
    logic [DATA_BITS-1:0]   r_rd_data;
    logic                   r_cs0;
    logic                   r_sclk;
    logic                   r_mosi;
    logic [FRAME_BITS-1:0]  w_frame;
    logic                   w_tick;

    assign w_frame = build_frame(rw, addr, wr_data);

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (r_state == SHIFT),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
            r_cs0     <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    // r_tx holds the bits still to go out; bit 31 is presented right away.
                    r_tx    <= {w_frame[FRAME_BITS-2:0], 1'b0};
                    r_mosi  <= w_frame[RW_BIT];
                    r_rw    <= rw;
                    r_cs0   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                    r_bit   <= '0;
                    r_state <= SETUP;
                end
                SETUP: if (r_cnt == SETUP_LAST) begin
                    r_sclk  <= 1'b1;
                    r_state <= SHIFT;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                SHIFT: if (w_tick) begin
                    if (r_sclk) begin
                        r_sclk <= 1'b0;
                        r_rx   <= {r_rx[DATA_BITS-2:0], spi_miso};
                        r_mosi <= r_tx[FRAME_BITS-1];
                        r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                    end else if (r_bit == 5'd31) begin
                        // The last bit's low half has elapsed; the clock stays parked low.
                        r_cnt   <= '0;
                        r_state <= HOLD;
                    end else begin
                        r_bit  <= r_bit + 5'd1;
                        r_sclk <= 1'b1;
                    end
                end
                HOLD: if (r_cnt == HOLD_LAST) begin
                    r_cs0   <= 1'b1;
                    r_done  <= 1'b1;
                    if (r_rw)
                        r_rd_data <= r_rx;
                    r_cnt   <= '0;
                    r_state <= GAP;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                GAP: if (r_cnt == GAP_LAST) begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_data  = r_rd_data;
    assign spi_cs0  = r_cs0;
    assign spi_clk  = r_sclk;
    assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench: default-parameter master plus a fast-timing master sharing one slave model.
module tb_spi_reg_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a, start_b, rw, sel;
    logic [14:0] addr;
    logic [15:0] wr_data;
    logic        miso = 1'b0;

    logic        busy_a, done_a, cs_a, sclk_a, mosi_a;
    logic        busy_b, done_b, cs_b, sclk_b, mosi_b;
    logic [15:0] rd_a, rd_b;

    logic        w_cs, w_sclk, w_mosi, w_busy, w_done;
    logic [15:0] w_rd;

    int cyc = 0, t0 = 0;
    int t_csfall = -1, t_csrise = -1, t_rise1 = -1, t_rise2 = -1, t_done = -1, t_idle = -1;
    int nrise = 0, nfall = 0, s_cnt = 0, done_cnt = 0;
    int vectors = 0, miscompares = 0;
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0;
    logic [31:0] s_in = '0, s_last = '0;
    logic [2:0]  s_addr = '0;
    logic [15:0] done_rd = '0;
    logic [15:0] mem [0:7] = '{16'h0, 16'h0, 16'hA5C3, 16'h0, 16'hBEEF, 16'h0, 16'h0, 16'h0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_master u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .rw(rw), .addr(addr), .wr_data(wr_data),
        .busy(busy_a), .done(done_a), .rd_data(rd_a),
        .spi_cs0(cs_a), .spi_clk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso)
    );

    spi_reg_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .rw(rw), .addr(addr), .wr_data(wr_data),
        .busy(busy_b), .done(done_b), .rd_data(rd_b),
        .spi_cs0(cs_b), .spi_clk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso)
    );

    assign w_cs   = sel ? cs_b   : cs_a;
    assign w_sclk = sel ? sclk_b : sclk_a;
    assign w_mosi = sel ? mosi_b : mosi_a;
    assign w_busy = sel ? busy_b : busy_a;
    assign w_done = sel ? done_b : done_a;
    assign w_rd   = sel ? rd_b   : rd_a;

    // Slave model and event monitor, sampled mid-cycle; miso moves after each master sample.
    always @(negedge clk) begin
        if (p_cs && !w_cs) begin
            t_csfall <= cyc; nrise <= 0; nfall <= 0; s_in <= '0; miso <= 1'b0;
        end
        if (!p_cs && w_cs) begin
            t_csrise <= cyc; s_last <= s_in; s_cnt <= nrise;
            if (nrise == 32 && !s_in[31]) mem[s_in[18:16]] <= s_in[15:0];
        end
        if (!w_cs && !p_sclk && w_sclk) begin
            nrise <= nrise + 1;
            s_in  <= {s_in[30:0], w_mosi};
            if (nrise == 0) t_rise1 <= cyc;
            if (nrise == 1) t_rise2 <= cyc;
        end
        if (!w_cs && p_sclk && !w_sclk) begin
            nfall <= nfall + 1;
            if (nfall == 15) begin
                s_addr <= s_in[2:0];
                miso   <= mem[s_in[2:0]][15];
            end else if (nfall >= 16 && nfall <= 30) begin
                miso <= mem[s_addr][30-nfall];
            end else begin
                miso <= 1'b0;
            end
        end
        if (w_done === 1'b1) begin
            done_cnt <= done_cnt + 1; t_done <= cyc; done_rd <= w_rd;
        end
        if (p_busy && !w_busy) t_idle <= cyc;
        p_cs   <= w_cs;
        p_sclk <= w_sclk;
        p_busy <= w_busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic i_rw, input logic [14:0] a, input logic [15:0] d);
        @(negedge clk);
        rw = i_rw; addr = a; wr_data = d;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (w_busy && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_timeout", 32'(w_busy), 0);
        @(negedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, r1, n;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        rw = 1'b0; addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs",   32'(cs_a),   1);
        chk("rst_sclk", 32'(sclk_a), 0);
        chk("rst_mosi", 32'(mosi_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_rd",   32'(rd_a),   0);
        @(negedge clk) reset_n = 1'b1;

        // Write 0x1234 to MOTOR (5)
        launch(1'b0, 15'h0005, 16'h1234);
        chk("wr_cs_low_t0", 32'(w_cs), 0);
        chk("wr_busy_t0",   32'(w_busy), 1);
        chk("wr_mosi_b31",  32'(w_mosi), 0);
        wait_idle();
        chk("wr_csfall",  32'(t_csfall - t0), 0);
        chk("wr_rise1",   32'(t_rise1 - t0), 2);
        chk("wr_done_t",  32'(t_done - t0), 260);
        chk("wr_csrise",  32'(t_csrise - t0), 260);
        chk("wr_idle_t",  32'(t_idle - t0), 262);
        chk("wr_stream",  s_last, 32'h0005_1234);
        chk("wr_nrise",   32'(s_cnt), 32);
        chk("wr_ndone",   32'(done_cnt), 1);
        chk("wr_rd_keep", 32'(done_rd), 0);
        chk("wr_mem5",    32'(mem[5]), 32'h1234);

        // Read STATUS (4) -> 0xBEEF
        launch(1'b1, 15'h0004, 16'hFFFF);
        chk("rd_mosi_b31", 32'(w_mosi), 1);
        wait_idle();
        chk("rd_stream",  s_last, 32'h8004_0000);
        chk("rd_done_rd", 32'(done_rd), 32'hBEEF);
        chk("rd_rd_hold", 32'(w_rd), 32'hBEEF);
        chk("rd_done_t",  32'(t_done - t0), 260);
        chk("rd_idle_t",  32'(t_idle - t0), 262);
        chk("rd_ndone",   32'(done_cnt), 2);

        // Back-to-back with start held high
        base = done_cnt;
        @(negedge clk);
        rw = 1'b0; addr = 15'h0001; wr_data = 16'h1111; start_a = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        n = 0;
        while (done_cnt != base + 1 && n < 400) begin @(negedge clk); #1; n++; end
        chk("b2b_first_done", 32'(done_cnt), 32'(base + 1));
        chk("b2b_first_t", 32'(t_done - t0), 260);
        r1 = t_csrise;
        n = 0;
        while (w_cs && n < 20) begin @(negedge clk); #1; n++; end
        start_a = 1'b0;
        chk("b2b_gap", 32'(t_csfall - r1), 3);
        wait_idle();
        chk("b2b_ndone", 32'(done_cnt), 32'(base + 2));
        chk("b2b_stream", s_last, 32'h0001_1111);
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_no_third", 32'(done_cnt), 32'(base + 2));
        chk("b2b_idle", 32'(w_busy), 0);

        // start pulsed mid-frame must be ignored
        base = done_cnt;
        launch(1'b0, 15'h0003, 16'hCAFE);
        repeat (99) @(posedge clk);
        @(negedge clk);
        rw = 1'b1; addr = 15'h0006; wr_data = 16'h0BAD; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("ign_at_100", 32'(cyc - t0), 100);
        rw = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("ign_ndone",  32'(done_cnt), 32'(base + 1));
        chk("ign_stream", s_last, 32'h0003_CAFE);
        chk("ign_done_t", 32'(t_done - t0), 260);
        chk("ign_mem6",   32'(mem[6]), 0);
        chk("ign_busy",   32'(w_busy), 0);

        // Asynchronous reset during SHIFT
        chk("pre_rst_rd", 32'(w_rd), 32'hBEEF);
        launch(1'b1, 15'h0004, 16'h0000);
        base = done_cnt;
        repeat (150) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_cs",   32'(cs_a),   1);
        chk("arst_sclk", 32'(sclk_a), 0);
        chk("arst_mosi", 32'(mosi_a), 0);
        chk("arst_busy", 32'(busy_a), 0);
        chk("arst_done", 32'(done_a), 0);
        chk("arst_rd",   32'(rd_a),   0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt), 32'(base));
        launch(1'b0, 15'h0007, 16'h5A5A);
        wait_idle();
        chk("post_stream", s_last, 32'h0007_5A5A);
        chk("post_mem7",   32'(mem[7]), 32'h5A5A);
        chk("post_done_t", 32'(t_done - t0), 260);
        chk("post_ndone",  32'(done_cnt), 32'(base + 1));

        // Fast timing instance: CLK_DIV=2, CS_SETUP=1, CS_HOLD=1
        sel = 1'b1;
        repeat (2) @(posedge clk);
        launch(1'b1, 15'h0002, 16'h0000);
        wait_idle();
        chk("fast_rd",     32'(done_rd), 32'hA5C3);
        chk("fast_rd_out", 32'(rd_b), 32'hA5C3);
        chk("fast_stream", s_last, 32'h8002_0000);
        chk("fast_rise1",  32'(t_rise1 - t0), 1);
        chk("fast_period", 32'(t_rise2 - t_rise1), 4);
        chk("fast_done_t", 32'(t_done - t0), 130);
        chk("fast_idle_t", 32'(t_idle - t0), 132);
        chk("fast_nrise",  32'(s_cnt), 32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
